// File: rtl/blob_position_arbiter.sv
// Round-robin arbiter for four blob position sources. It keeps the winning
// coordinates in a shadow register and commits them on the rising edge of vsync.
// Optional coordinate clamping is enabled when BLOB_POS_CLAMP_EN is defined.
module blob_position_arbiter #(
  parameter int INIT_X   = 512,
  parameter int INIT_Y   = 384,
  parameter int SCREEN_W = 1024,
  parameter int SCREEN_H = 768,
  parameter int BLOB_W   = 64,
  parameter int BLOB_H   = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic        [3:0]  req,
  input  logic        [47:0] req_x,
  input  logic        [47:0] req_y,
  input  logic               vsync,
  output logic        [3:0]  grant,
  output logic signed [11:0] blob_x,
  output logic signed [11:0] blob_y,
  output logic               pending,
  output logic               frame_update
);

  typedef enum logic {ACCEPT, COMMIT} state_t;

`ifdef BLOB_POS_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  localparam logic signed [11:0] RST_X = 12'(INIT_X);
  localparam logic signed [11:0] RST_Y = 12'(INIT_Y);
  localparam logic signed [11:0] X_LO  = 12'(BLOB_W / 2);
  localparam logic signed [11:0] X_HI  = 12'(SCREEN_W - BLOB_W / 2);
  localparam logic signed [11:0] Y_LO  = 12'(BLOB_H / 2);
  localparam logic signed [11:0] Y_HI  = 12'(SCREEN_H - BLOB_H / 2);

  state_t             state;
  logic [1:0]         rr_ptr;
  logic               vsync_d;
  logic               armed;
  logic signed [11:0] shadow_x;
  logic signed [11:0] shadow_y;

  logic               rise;
  logic               hit;
  logic [1:0]         sel;
  logic [1:0]         idx;
  logic signed [11:0] raw_x;
  logic signed [11:0] raw_y;
  logic signed [11:0] cap_x;
  logic signed [11:0] cap_y;

  function automatic logic signed [11:0] clamp12(input logic signed [11:0] v,
                                                 input logic signed [11:0] lo,
                                                 input logic signed [11:0] hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

  // vsync_d resets to 0, so 'armed' keeps a vsync that is already high when
  // reset is released from being treated as a rising edge.
  always_comb begin
    rise = vsync & ~vsync_d & armed;
    hit  = 1'b0;
    sel  = rr_ptr;
    idx  = rr_ptr;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = rr_ptr + 2'(i);
      if (!hit && req[idx]) begin
        hit = 1'b1;
        sel = idx;
      end
    end
    raw_x = req_x[12*sel +: 12];
    raw_y = req_y[12*sel +: 12];
    cap_x = CLAMP_EN ? clamp12(raw_x, X_LO, X_HI) : raw_x;
    cap_y = CLAMP_EN ? clamp12(raw_y, Y_LO, Y_HI) : raw_y;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ACCEPT;
      rr_ptr       <= '0;
      vsync_d      <= 1'b0;
      armed        <= 1'b0;
      shadow_x     <= RST_X;
      shadow_y     <= RST_Y;
      blob_x       <= RST_X;
      blob_y       <= RST_Y;
      grant        <= '0;
      pending      <= 1'b0;
      frame_update <= 1'b0;
    end else begin
      vsync_d      <= vsync;
      armed        <= 1'b1;
      grant        <= '0;
      frame_update <= 1'b0;
      case (state)
        ACCEPT: begin
          if (hit) begin
            grant    <= 4'(1) << sel;
            shadow_x <= cap_x;
            shadow_y <= cap_y;
            pending  <= 1'b1;
            rr_ptr   <= sel + 2'd1;
          end
          if (rise) state <= COMMIT;
        end
        COMMIT: begin
          if (pending) begin
            blob_x       <= shadow_x;
            blob_y       <= shadow_y;
            frame_update <= 1'b1;
            pending      <= 1'b0;
          end
          state <= ACCEPT;
        end
        default: state <= ACCEPT;
      endcase
    end
  end

endmodule

// File: tb/tb_blob_position_arbiter.sv
// Testbench for blob_position_arbiter. It runs directed and random stimulus
// and compares every cycle against a frame-level reference model.
module tb_blob_position_arbiter;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic        [3:0]  req = '0;
  logic        [47:0] req_x = '0;
  logic        [47:0] req_y = '0;
  logic               vsync = 1'b0;
  logic        [3:0]  grant;
  logic signed [11:0] blob_x;
  logic signed [11:0] blob_y;
  logic               pending;
  logic               frame_update;

  int checks = 0;
  int failures = 0;

  blob_position_arbiter #(
    .INIT_X(512), .INIT_Y(384), .SCREEN_W(1024), .SCREEN_H(768), .BLOB_W(64), .BLOB_H(64)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_x(req_x), .req_y(req_y), .vsync(vsync),
    .grant(grant), .blob_x(blob_x), .blob_y(blob_y), .pending(pending),
    .frame_update(frame_update)
  );

  always #5 clk = ~clk;

  // Reference model: a frame commits one cycle after a vsync rise.
  bit commit_next;
  int m_rr, m_shx, m_shy, m_bx, m_by, m_grant;
  bit m_pend, m_fu, m_vprev, m_armed;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               tag, $signed(got), got, $signed(exp), exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
`ifdef BLOB_POS_CLAMP_EN
    return (v < lo) ? lo : (v > hi) ? hi : v;
`else
    return v;
`endif
  endfunction

  function automatic int slice(input logic [47:0] bus, input int s);
    logic signed [11:0] v;
    v = bus[12*s +: 12];
    return int'(v);
  endfunction

  task automatic model_reset();
    commit_next = 0; m_rr = 0; m_shx = 512; m_shy = 384; m_bx = 512; m_by = 384;
    m_grant = 0; m_pend = 0; m_fu = 0; m_vprev = 0; m_armed = 0;
  endtask

  task automatic model_clock();
    bit rise;
    bit found;
    rise = vsync && !m_vprev && m_armed;
    m_grant = 0;
    m_fu = 0;
    if (commit_next) begin
      if (m_pend) begin
        m_bx = m_shx; m_by = m_shy; m_fu = 1; m_pend = 0;
      end
      commit_next = 0;
    end else begin
      found = 0;
      for (int k = 0; k < 4; k++) begin
        int s;
        s = (m_rr + k) % 4;
        if (!found && req[s]) begin
          found = 1;
          m_grant = 1 << s;
          m_shx = clampi(slice(req_x, s), 32, 992);
          m_shy = clampi(slice(req_y, s), 32, 736);
          m_pend = 1;
          m_rr = (s + 1) % 4;
        end
      end
      if (rise) commit_next = 1;
    end
    m_vprev = vsync;
    m_armed = 1;
  endtask

  task automatic compare_all(input string ph);
    check({ph, "_grant"}, 32'(grant), m_grant);
    check({ph, "_blob_x"}, blob_x, m_bx);
    check({ph, "_blob_y"}, blob_y, m_by);
    check({ph, "_pending"}, 32'(pending), 32'(m_pend));
    check({ph, "_frame_update"}, 32'(frame_update), 32'(m_fu));
  endtask

  // Inputs are set at the negedge, and the model advances with the DUT edge.
  task automatic step(input string ph);
    @(posedge clk);
    model_clock();
    #1;
    compare_all(ph);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all("reset");
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic set_src(input int s, input int x, input int y);
    req_x[12*s +: 12] = 12'(x);
    req_y[12*s +: 12] = 12'(y);
  endtask

  initial begin
    model_reset();
    do_reset();

    // vsync already high when reset is released is not an edge; the capture must stay uncommitted
    vsync = 1; req = 4'b0001; set_src(0, 7, 9);
    step("first");
    req = 0;
    step("first_hold");
    check("first_no_commit_x", blob_x, 512);
    check("first_pending", 32'(pending), 1);
    vsync = 0; step("first_low");
    vsync = 1; step("first_rise");
    vsync = 0; step("first_commit");
    check("first_commit_x", blob_x, 7);

    // reset, then a lone vsync pulse with no requests
    do_reset();
    repeat (3) step("idle");
    vsync = 1; step("idle_rise");
    vsync = 0; step("idle_commit");
    check("idle_blob_x", blob_x, 512);
    check("idle_blob_y", blob_y, 384);
    check("idle_no_fu", 32'(frame_update), 0);

    // single request from source 2
    req = 4'b0100; set_src(2, 100, 200);
    step("s2_cap");
    check("s2_grant", 32'(grant), 4);
    check("s2_pending", 32'(pending), 1);
    req = 0; vsync = 1; step("s2_rise");
    vsync = 0; step("s2_commit");
    check("s2_blob_x", blob_x, 100);
    check("s2_blob_y", blob_y, 200);
    check("s2_fu", 32'(frame_update), 1);
    check("s2_pend_clr", 32'(pending), 0);

    // all sources requesting
    for (int i = 0; i < 4; i++) set_src(i, 10 * (i + 1), 20 * (i + 1));
    req = 4'b1111;
    repeat (8) step("rr_all");
    req = 0;

    // last capture in the frame wins
    req = 4'b0001; set_src(0, 10, 10); step("lw0");
    req = 4'b0010; set_src(1, 300, 50); step("lw1");
    req = 0; vsync = 1; step("lw_rise");
    vsync = 0; step("lw_commit");
    check("lw_blob_x", blob_x, 300);
    check("lw_blob_y", blob_y, 50);
    step("lw_after");
    check("lw_fu_single", 32'(frame_update), 0);

    // capture in the same cycle as the rise, then a request during COMMIT
    req = 4'b1000; set_src(3, 123, 456); vsync = 1; step("same_rise");
    check("same_grant", 32'(grant), 8);
    req = 4'b0010; set_src(1, 222, 333); step("same_commit");
    check("commit_no_grant", 32'(grant), 0);
    check("same_blob_x", blob_x, 123);
    check("same_blob_y", blob_y, 456);
    step("after_commit");
    check("delayed_grant", 32'(grant), 2);
    req = 0;
    repeat (6) step("vsync_held");
    check("held_blob_x", blob_x, 123);
    check("held_pending", 32'(pending), 1);
    vsync = 0; step("held_low");
    vsync = 1; step("held_rise");
    vsync = 0; step("held_commit");
    check("delayed_blob_x", blob_x, 222);

    // out-of-range coordinates
    req = 4'b0001; set_src(0, -20, 900); step("clamp_cap");
    req = 0; vsync = 1; step("clamp_rise");
    vsync = 0; step("clamp_commit");
`ifdef BLOB_POS_CLAMP_EN
    check("clamp_blob_x", blob_x, 32);
    check("clamp_blob_y", blob_y, 736);
`else
    check("clamp_blob_x", blob_x, -20);
    check("clamp_blob_y", blob_y, 900);
`endif

    // random traffic with one reset in the middle
    for (int n = 0; n < 2000; n++) begin
      req = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      req_x = {$urandom, $urandom};
      req_y = {$urandom, $urandom};
      if ($urandom_range(0, 19) == 0) vsync = ~vsync;
      if (n == 1000) do_reset();
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
